// File: rtl/ctr_sequencer_pkg.sv
// ctr_sequencer shared types.
// State encoding, counter control codes and the phase table entry.
package ctr_sequencer_pkg;

  localparam int PKG_LEN_W = 8;

  localparam logic [1:0] CTRL_HOLD = 2'b00;
  localparam logic [1:0] CTRL_LOAD = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [1:0]           mode;
    logic [PKG_LEN_W-1:0] len;
  } phase_entry_t;

endpackage

// File: rtl/ctr_sequencer_table.sv
// ctr_phase_table: per-phase {mode, len} storage.
// Synchronous write, combinational read.
module ctr_phase_table
  import ctr_sequencer_pkg::*;
#(
  parameter int PHASES = 4,
  parameter int AW     = (PHASES > 1) ? $clog2(PHASES) : 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  phase_entry_t  wr_entry,
  input  logic [AW-1:0] rd_addr,
  output phase_entry_t  rd_entry
);

  phase_entry_t tbl_q [PHASES];
  phase_entry_t tbl_d [PHASES];

  // next table contents: one entry replaced on write
  always_comb begin
    tbl_d = tbl_q;
    if (wr_en) tbl_d[wr_addr] = wr_entry;
  end

  // table storage; entries reset to hold for one cycle
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < PHASES; i++) begin
        tbl_q[i] <= '{mode: CTRL_HOLD, len: PKG_LEN_W'(1)};
      end
    end else begin
      tbl_q <= tbl_d;
    end
  end

  assign rd_entry = tbl_q[rd_addr];

endmodule

// File: rtl/ctr_sequencer.sv
// ctr_sequencer: table-driven counter control sequencer.
// IDLE -> LOAD -> RUN (phases) -> DONE, all outputs registered.
module ctr_sequencer
  import ctr_sequencer_pkg::*;
#(
  parameter int COUNTER_SIZE = 3,
  parameter int PHASES       = 4,
  parameter int LEN_W        = PKG_LEN_W,
  parameter int AW           = (PHASES > 1) ? $clog2(PHASES) : 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [1:0]              wr_mode,
  input  logic [LEN_W-1:0]        wr_len,
  input  logic [AW-1:0]           last_phase,
  input  logic                    loop_en,
  input  logic [COUNTER_SIZE-1:0] load_value,
  input  logic                    start,
  input  logic                    abort,
  output logic [1:0]              control,
  output logic [COUNTER_SIZE-1:0] initial_value,
  output logic                    INIT,
  output logic                    busy,
  output logic                    done,
  output logic [AW-1:0]           phase
);

  state_e                  state_q, state_d;
  logic [AW-1:0]           phase_q, phase_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]           last_q, last_d;
  logic                    loop_q, loop_d;
  logic [1:0]              control_q, control_d;
  logic [COUNTER_SIZE-1:0] ival_q, ival_d;
  logic                    init_q, init_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    tbl_we;
  logic [AW-1:0]           rd_addr;
  logic [AW-1:0]           phase_inc;
  phase_entry_t            wr_entry;
  phase_entry_t            rd_entry;

  assign wr_entry = '{mode: wr_mode, len: PKG_LEN_W'(wr_len)};
  assign tbl_we   = wr_en && (state_q == ST_IDLE);

  ctr_phase_table #(
    .PHASES (PHASES),
    .AW     (AW)
  ) u_table (
    .clock    (clock),
    .reset_n  (reset_n),
    .wr_en    (tbl_we),
    .wr_addr  (wr_addr),
    .wr_entry (wr_entry),
    .rd_addr  (rd_addr),
    .rd_entry (rd_entry)
  );

  // next state, table read address and registered output values
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    loop_d    = loop_q;
    control_d = control_q;
    ival_d    = ival_q;
    init_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_addr   = phase_q;
    phase_inc = AW'(phase_q + 1'b1);
    unique case (state_q)
      ST_IDLE: begin
        control_d = CTRL_HOLD;
        busy_d    = 1'b0;
        if (start) begin
          state_d   = ST_LOAD;
          last_d    = last_phase;
          loop_d    = loop_en;
          ival_d    = load_value;
          init_d    = 1'b1;
          control_d = CTRL_LOAD;
          busy_d    = 1'b1;
          phase_d   = '0;
        end
      end
      ST_LOAD: begin
        state_d   = ST_RUN;
        rd_addr   = '0;
        phase_d   = '0;
        control_d = rd_entry.mode;
        cnt_d     = LEN_W'(rd_entry.len - 1'b1);
        busy_d    = 1'b1;
      end
      ST_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (phase_q != last_q) begin
          rd_addr   = phase_inc;
          phase_d   = phase_inc;
          control_d = rd_entry.mode;
          cnt_d     = LEN_W'(rd_entry.len - 1'b1);
        end else if (loop_q) begin
          rd_addr   = '0;
          phase_d   = '0;
          control_d = rd_entry.mode;
          cnt_d     = LEN_W'(rd_entry.len - 1'b1);
        end else begin
          state_d   = ST_DONE;
          control_d = CTRL_HOLD;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        control_d = CTRL_HOLD;
        busy_d    = 1'b0;
      end
      default: begin
        state_d   = ST_IDLE;
        control_d = CTRL_HOLD;
        busy_d    = 1'b0;
      end
    endcase
    if (abort) begin
      state_d   = ST_IDLE;
      phase_d   = '0;
      control_d = CTRL_HOLD;
      init_d    = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
    end
  end

  // state and output registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      cnt_q     <= '0;
      last_q    <= '0;
      loop_q    <= 1'b0;
      control_q <= CTRL_HOLD;
      ival_q    <= '0;
      init_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      loop_q    <= loop_d;
      control_q <= control_d;
      ival_q    <= ival_d;
      init_q    <= init_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign control       = control_q;
  assign initial_value = ival_q;
  assign INIT          = init_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign phase         = phase_q;

endmodule

// File: tb/tb_ctr_sequencer.sv
// tb_ctr_sequencer: directed checks of ctr_sequencer.
// Phase durations measured by counting cycles per control code.
module tb_ctr_sequencer;

  logic       clock;
  logic       reset_n;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [1:0] wr_mode;
  logic [7:0] wr_len;
  logic [1:0] last_phase;
  logic       loop_en;
  logic [2:0] load_value;
  logic       start;
  logic       abort;
  logic [1:0] control;
  logic [2:0] initial_value;
  logic       INIT;
  logic       busy;
  logic       done;
  logic [1:0] phase;

  int n_checks;
  int n_fail;

  ctr_sequencer dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_mode       (wr_mode),
    .wr_len        (wr_len),
    .last_phase    (last_phase),
    .loop_en       (loop_en),
    .load_value    (load_value),
    .start         (start),
    .abort         (abort),
    .control       (control),
    .initial_value (initial_value),
    .INIT          (INIT),
    .busy          (busy),
    .done          (done),
    .phase         (phase)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_entry(input logic [1:0] a,
                             input logic [1:0] m,
                             input logic [7:0] l);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_mode = m;
    wr_len  = l;
    tick();
    wr_en   = 1'b0;
  endtask

  // counts consecutive cycles showing code (bounded), and INIT highs
  task automatic measure(input logic [1:0] code,
                         output int n, output int inits);
    n = 0;
    inits = 0;
    while (control === code && busy === 1'b1 && n < 400) begin
      if (INIT === 1'b1) inits++;
      n++;
      tick();
    end
  endtask

  task automatic setup_table();
    write_entry(2'd0, 2'b10, 8'd5);
    write_entry(2'd1, 2'b11, 8'd3);
  endtask

  task automatic do_start(input logic [1:0] lp, input logic le,
                          input logic [2:0] lv);
    last_phase = lp;
    loop_en    = le;
    load_value = lv;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({control, INIT, busy, done, phase, initial_value} !== 10'b0) begin
      $display("FAIL reset_outs: got %b want 0",
               {control, INIT, busy, done, phase, initial_value});
      n_fail++;
    end
    reset_n = 1'b1;
    do_start(2'd0, 1'b0, 3'd0);
    tick();
    n_checks++;
    if (control !== 2'b00 || busy !== 1'b1) begin
      $display("FAIL reset_table: ctl=%b busy=%b want 00/1", control, busy);
      n_fail++;
    end
    tick();
    n_checks++;
    if (done !== 1'b1) begin
      $display("FAIL reset_table_len: done=%b want 1", done);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_single_run();
    int n, k;
    setup_table();
    do_start(2'd1, 1'b0, 3'd3);
    n_checks++;
    if (INIT !== 1'b1 || initial_value !== 3'b011 ||
        control !== 2'b01 || busy !== 1'b1) begin
      $display("FAIL load: init=%b iv=%b ctl=%b busy=%b want 1/011/01/1",
               INIT, initial_value, control, busy);
      n_fail++;
    end
    tick();
    n_checks++;
    if (INIT !== 1'b0 || phase !== 2'd0) begin
      $display("FAIL run_enter: init=%b phase=%0d want 0/0", INIT, phase);
      n_fail++;
    end
    measure(2'b10, n, k);
    n_checks++;
    if (n !== 5) begin
      $display("FAIL phase0_len: got %0d want 5", n);
      n_fail++;
    end
    n_checks++;
    if (phase !== 2'd1) begin
      $display("FAIL phase_idx: got %0d want 1", phase);
      n_fail++;
    end
    measure(2'b11, n, k);
    n_checks++;
    if (n !== 3) begin
      $display("FAIL phase1_len: got %0d want 3", n);
      n_fail++;
    end
    n_checks++;
    if (done !== 1'b1 || control !== 2'b00 || busy !== 1'b0) begin
      $display("FAIL done: done=%b ctl=%b busy=%b want 1/00/0",
               done, control, busy);
      n_fail++;
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || initial_value !== 3'b011) begin
      $display("FAIL after_done: done=%b iv=%b want 0/011",
               done, initial_value);
      n_fail++;
    end
  endtask

  task automatic test_loop_abort();
    int n, k;
    do_start(2'd1, 1'b1, 3'd6);
    tick();
    for (int it = 0; it < 3; it++) begin
      measure(2'b10, n, k);
      n_checks++;
      if (n !== 5 || k !== 0) begin
        $display("FAIL loop_p0[%0d]: len=%0d init=%0d want 5/0", it, n, k);
        n_fail++;
      end
      measure(2'b11, n, k);
      n_checks++;
      if (n !== 3 || k !== 0) begin
        $display("FAIL loop_p1[%0d]: len=%0d init=%0d want 3/0", it, n, k);
        n_fail++;
      end
    end
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || control !== 2'b00 || done !== 1'b0) begin
      $display("FAIL abort: busy=%b ctl=%b done=%b want 0/00/0",
               busy, control, done);
      n_fail++;
    end
    k = 0;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1 || busy === 1'b1) k++;
      tick();
    end
    n_checks++;
    if (k !== 0) begin
      $display("FAIL abort_quiet: active cycles %0d want 0", k);
      n_fail++;
    end
  endtask

  task automatic test_len_zero();
    int n, k;
    write_entry(2'd0, 2'b10, 8'd0);
    do_start(2'd0, 1'b0, 3'd1);
    tick();
    measure(2'b10, n, k);
    n_checks++;
    if (n !== 256) begin
      $display("FAIL len_zero: got %0d want 256", n);
      n_fail++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      $display("FAIL len_zero_done: got %b want 1", done);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_busy_ignore();
    int n, k;
    setup_table();
    do_start(2'd1, 1'b0, 3'd2);
    tick();
    tick();
    start   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 2'd0;
    wr_mode = 2'b01;
    wr_len  = 8'd2;
    tick();
    start   = 1'b0;
    wr_en   = 1'b0;
    measure(2'b10, n, k);
    n_checks++;
    if (n !== 3 || k !== 0) begin
      $display("FAIL busy_p0_rest: len=%0d init=%0d want 3/0", n, k);
      n_fail++;
    end
    measure(2'b11, n, k);
    n_checks++;
    if (n !== 3 || done !== 1'b1) begin
      $display("FAIL busy_p1: len=%0d done=%b want 3/1", n, done);
      n_fail++;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (INIT !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL start_in_done: init=%b busy=%b want 0/0", INIT, busy);
      n_fail++;
    end
    do_start(2'd1, 1'b0, 3'd2);
    tick();
    measure(2'b10, n, k);
    n_checks++;
    if (n !== 5) begin
      $display("FAIL readback_p0: got %0d want 5", n);
      n_fail++;
    end
    measure(2'b11, n, k);
    n_checks++;
    if (n !== 3) begin
      $display("FAIL readback_p1: got %0d want 3", n);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_mid_reset();
    int n, k;
    do_start(2'd1, 1'b0, 3'd7);
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    n_checks++;
    if ({control, INIT, busy, done, phase, initial_value} !== 10'b0) begin
      $display("FAIL mid_reset: got %b want 0",
               {control, INIT, busy, done, phase, initial_value});
      n_fail++;
    end
    reset_n = 1'b1;
    setup_table();
    do_start(2'd1, 1'b0, 3'd5);
    n_checks++;
    if (INIT !== 1'b1 || initial_value !== 3'd5) begin
      $display("FAIL restart_load: init=%b iv=%0d want 1/5",
               INIT, initial_value);
      n_fail++;
    end
    tick();
    n_checks++;
    if (phase !== 2'd0 || control !== 2'b10) begin
      $display("FAIL restart_p0: phase=%0d ctl=%b want 0/10", phase, control);
      n_fail++;
    end
    measure(2'b10, n, k);
    measure(2'b11, n, k);
    n_checks++;
    if (done !== 1'b1) begin
      $display("FAIL restart_done: got %b want 1", done);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_short();
    int b;
    write_entry(2'd0, 2'b10, 8'd1);
    do_start(2'd0, 1'b0, 3'd4);
    b = 0;
    for (int i = 0; i < 6 && busy === 1'b1; i++) begin
      b++;
      tick();
    end
    n_checks++;
    if (b !== 2 || done !== 1'b1) begin
      $display("FAIL short: busy=%0d done=%b want 2/1", b, done);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_start_with_write();
    int n, k;
    wr_en   = 1'b1;
    wr_addr = 2'd0;
    wr_mode = 2'b11;
    wr_len  = 8'd2;
    do_start(2'd0, 1'b0, 3'd0);
    wr_en   = 1'b0;
    tick();
    measure(2'b11, n, k);
    n_checks++;
    if (n !== 2 || done !== 1'b1) begin
      $display("FAIL start_write: len=%0d done=%b want 2/1", n, done);
      n_fail++;
    end
    tick();
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_mode    = '0;
    wr_len     = '0;
    last_phase = '0;
    loop_en    = 1'b0;
    load_value = '0;
    start      = 1'b0;
    abort      = 1'b0;
    test_reset();
    test_single_run();
    test_loop_abort();
    test_len_zero();
    test_busy_ignore();
    test_mid_reset();
    test_short();
    test_start_with_write();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
